// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: FSM state codes and default parameters.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned DefMemTimeout = 15;
  localparam int unsigned DefCntW       = 32;

  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StMemWait = 2'd1;
  localparam logic [1:0] StError   = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Event counter that clears on synchronous reset and sticks at its all-ones maximum.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Per-cycle advance/hold/flush decision for the five-stage pipeline, with a
// data-memory wait FSM (timeout into a sticky ERROR state) and stall/flush counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = DefMemTimeout,
  parameter int unsigned CNT_W       = DefCntW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rd,
  input  logic             exmem_branch,
  input  logic             exmem_zero,
  input  logic             exmem_addermuxselect,
  input  logic             exmem_memread,
  input  logic             exmem_memwrite,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             pc_src,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             exmem_hold,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WW = $clog2(MEM_TIMEOUT + 1);

  logic [1:0]    state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          mem_error_q, mem_error_d;
  logic          memop, ack_valid, mem_stall, taken, load_use;
  logic          stall_ev, flush_ev;

  assign memop     = exmem_memread | exmem_memwrite;
  assign dmem_req  = ~reset & memop & (state_q != StError);
  // An ack without a pending request never completes a wait.
  assign ack_valid = dmem_req & dmem_ack;
  assign mem_stall = (dmem_req & ~dmem_ack) | (state_q == StError);
  assign taken     = exmem_addermuxselect | (exmem_branch & exmem_zero);
  assign load_use  = idex_memread & (idex_rd != 5'd0) &
                     ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2));

  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    pc_src      = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    exmem_hold  = 1'b0;
    stall_ev    = 1'b0;
    flush_ev    = 1'b0;
    if (reset) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (mem_stall) begin
      // Branch stays parked in EX/MEM, so its redirect waits for the ack cycle.
      exmem_hold = 1'b1;
      idex_flush = 1'b1;
      stall_ev   = 1'b1;
    end else if (taken) begin
      pc_src      = 1'b1;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      flush_ev    = 1'b1;
    end else if (load_use) begin
      idex_flush = 1'b1;
      stall_ev   = 1'b1;
    end else begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    mem_error_d = mem_error_q;
    case (state_q)
      StRun: begin
        if (memop && !dmem_ack) begin
          state_d = StMemWait;
          wcnt_d  = WW'(1);
        end
      end
      StMemWait: begin
        if (ack_valid) begin
          state_d = StRun;
          wcnt_d  = '0;
        end else if (wcnt_q == WW'(MEM_TIMEOUT)) begin
          state_d     = StError;
          mem_error_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      StError: ;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRun;
      wcnt_q      <= '0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      mem_error_q <= mem_error_d;
    end
  end

  assign mem_error = mem_error_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_ev),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_ev),
    .cnt   (flush_cnt)
  );

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard and sequencing controller for the five-stage RV64 pipeline. It decides per cycle whether the pipeline registers advance, hold or flush. Inputs are the IF/ID, ID/EX and EX/MEM pipeline register outputs and the data-memory handshake. Outputs are the PC and IF/ID write enables, the IF/ID, ID/EX and EX/MEM flush inputs, an EX/MEM hold and the PC source select. It also runs a data-memory wait state machine with timeout and keeps saturating stall and flush event counters.

## Interface
- MEM_TIMEOUT, 15: maximum consecutive cycles spent waiting for dmem_ack before the controller enters ERROR (must be ≥1).
- CNT_W, 32: width of each event counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- ifid_rs1, ifid_rs2  in  5  source register indices of the instruction in IF/ID.
- idex_memread  in  1  ID/EX holds a load.
- idex_rd  in  5  destination register index in ID/EX.
- exmem_branch, exmem_zero, exmem_addermuxselect  in  1  EX/MEM branch, ALU-zero and jump flags.
- exmem_memread, exmem_memwrite  in  1  EX/MEM holds a load or a store.
- dmem_ack  in  1  data memory completes the access this cycle.
- dmem_req  out  1  data-memory access request.
- pc_write, ifid_write  out  1  PC and IF/ID load enables.
- pc_src  out  1  1 selects the branch/jump target from EX/MEM.
- ifid_flush, idex_flush, exmem_flush  out  1  pipeline register flushes.
- exmem_hold  out  1  EX/MEM recirculates its current contents.
- mem_error  out  1  sticky flag: timeout occurred.
- stall_cnt, flush_cnt  out  CNT_W  event counters.

## Operation
- States: RUN, MEM_WAIT, ERROR. A wait counter wcnt of width clog2(MEM_TIMEOUT+1) runs alongside the state.
- memop = exmem_memread | exmem_memwrite.
- dmem_req = memop & (state != ERROR).
- mem_stall = (dmem_req & ~dmem_ack) | (state == ERROR).
- RUN transitions:
  - memop & ~dmem_ack → MEM_WAIT, wcnt = 1.
  - Otherwise stay in RUN.
- MEM_WAIT transitions:
  - dmem_ack → RUN, wcnt = 0.
  - wcnt == MEM_TIMEOUT & ~dmem_ack → ERROR, mem_error = 1.
  - Otherwise wcnt + 1.
- ERROR is left only by reset.
- taken = exmem_addermuxselect | (exmem_branch & exmem_zero).
- load_use = idex_memread & (idex_rd != 0) & (idex_rd == ifid_rs1 | idex_rd == ifid_rs2).
- Priority of the per-cycle action, highest first:
  1. mem_stall: pc_write = 0, ifid_write = 0, exmem_hold = 1, idex_flush = 1, all other flushes 0, pc_src = 0. Branch resolution is deferred because the branch stays in EX/MEM.
  2. taken: pc_src = 1, pc_write = 1, ifid_write = 1, and ifid_flush, idex_flush, exmem_flush all 1. The redirect beats load_use.
  3. load_use: pc_write = 0, ifid_write = 0, idex_flush = 1 (bubble).
  4. Default: pc_write = 1, ifid_write = 1, all flushes 0, exmem_hold = 0, pc_src = 0.
- Counters:
  - stall_cnt increments in any cycle with action 1 or 3.
  - flush_cnt increments in any cycle with action 2.
  - Both saturate at 2^CNT_W − 1.
- Reset (synchronous, while reset = 1):
  - state = RUN, wcnt = 0, mem_error = 0, stall_cnt = 0, flush_cnt = 0.
  - Outputs are forced: dmem_req = 0, pc_write = 0, ifid_write = 0, pc_src = 0, exmem_hold = 0, ifid_flush = idex_flush = exmem_flush = 1.
  - Reset asserted in MEM_WAIT or ERROR abandons the access; the next cycle after reset is RUN.

## Timing
- All control outputs are combinational from the current inputs plus the registered state, mem_error and counters. They take effect at the same posedge as the pipeline registers they drive, so latency is 0 cycles.
- State, wcnt, mem_error and counters update at posedge.
- A counter value reflects events up to the previous cycle.
- A single-cycle access (ack in the request cycle) causes no stall and no state change.
- An access acked N cycles late costs exactly N stall cycles.
- The timeout triggers on the posedge after MEM_TIMEOUT unacked cycles in MEM_WAIT.
- dmem_ack with no dmem_req is ignored.

## Structure
- Shared package: the state enum (RUN, MEM_WAIT, ERROR) and the default parameter constants.
- Sub-modules:
  - One `sat_counter` sub-module (parameter W, inputs clk, reset, inc; output cnt), instantiated twice.
  - No other sub-modules.
- The wait counter and FSM are inline.

## Test plan
- Load-use: ID/EX holds a load with idex_rd = 5, IF/ID has rs2 = 5, no memop → one cycle of pc_write = 0, ifid_write = 0, idex_flush = 1; stall_cnt goes 0 → 1. The same case with idex_rd = 0 produces no stall.
- Taken branch: exmem_branch = 1, exmem_zero = 1, no memop → pc_src = 1 and all three flushes 1 for one cycle; flush_cnt = 1. The same case with exmem_zero = 0 gives the default action.
- Memory wait: a store in EX/MEM with dmem_ack late by 3 cycles → dmem_req held for 4 cycles, exmem_hold = 1 for 3 cycles, state returns to RUN, stall_cnt = 3.
- Timeout: MEM_TIMEOUT = 4, dmem_ack never asserted → ERROR after 5 stall cycles; mem_error = 1 and dmem_req = 0 thereafter. Pulsing reset returns to RUN with all counters 0.
- Simultaneous events:
  - Jump, load_use and a pending load with no ack in the same cycle → stall wins; the redirect happens in the ack cycle only.
  - A taken branch together with load_use → redirect and flushes, no load-use stall.
- Saturation: with CNT_W = 4, force 20 load_use cycles → stall_cnt holds at 15.
